vga_pixel_fetcher: RTL and testbench
====================================

# vga_pixel_fetcher

Prefetches framebuffer pixels from SDRAM and presents them to the VGA timing generator one pixel per visible clock. It sits directly upstream of the VGA controller:
- It drives the controller's iRed/iGreen/iBlue.
- It consumes the controller's per-pixel request and top-of-screen strobe.
- It issues single-word pipelined reads on an Avalon-style read master and buffers the returned words in a small show-ahead FIFO.

## Interface
Parameters:
- FRAME_BASE, 0: word address of pixel (0,0).
- PIXELS, 307200: words per frame (640×480).
- DEPTH, 64: FIFO entries; power of two.
- MAX_OUTSTANDING, 8: maximum reads accepted but not yet returned.

Ports:
- iCLK  in  1  pixel clock; same clock as the VGA controller.
- iRST_N  in  1  reset: asynchronous, active-low.
- iPixelRequest  in  1  connect to the controller's oRequest; pops one pixel.
- iTopOfScreen  in  1  connect to the controller's oTopOfScreen; restarts the frame.
- oRed, oGreen, oBlue  out  4 each  FIFO head pixel; 0 when the FIFO is empty.
- oMemRead  out  1  read request.
- oMemAddress  out  22  word address.
- iMemWaitRequest  in  1  request stalled; oMemRead and oMemAddress must hold.
- iMemReadDataValid  in  1  one returned word this cycle.
- iMemReadData  in  16  returned word; [11:8]=R, [7:4]=G, [3:0]=B, [15:12] ignored.
- oUnderflow  out  1  sticky; set when a pop hits an empty FIFO.
- oFifoLevel  out  7  current FIFO occupancy, 0..DEPTH.

## Operation
States: WAIT_SYNC, FLUSH, FETCH.
- Reset enters WAIT_SYNC.
- Any state with iTopOfScreen=1 goes to FLUSH. In the same cycle:
  - fetch address ← FRAME_BASE; fetched count ← 0.
  - FIFO cleared; oUnderflow cleared.
- FLUSH:
  - No new reads are issued.
  - Returning words are discarded; each decrements outstanding.
  - Moves to FETCH in the cycle after outstanding reaches 0.
- FETCH, issue condition: oMemRead=1 when fetched < PIXELS, outstanding < MAX_OUTSTANDING, and level + outstanding < DEPTH.
- FETCH, accept (oMemRead & !iMemWaitRequest): address +1, fetched +1, outstanding +1.
- FETCH, wait state: while iMemWaitRequest=1, oMemRead stays 1 and oMemAddress stays stable. The issue condition is re-evaluated only after an accept.
- Return: iMemReadDataValid pushes R/G/B into the FIFO and decrements outstanding. Accept and return in the same cycle leave outstanding unchanged.
- End of frame: when fetched == PIXELS, oMemRead stays 0 until the next iTopOfScreen.
- Pop on iPixelRequest=1:
  - FIFO non-empty: the head advances.
  - FIFO empty: oUnderflow ← 1; no pointer change; outputs stay 0.
- Push and pop in the same cycle leave level unchanged. Push to an empty FIFO with a simultaneous pop is not a valid pop: the pop counts as underflow.
- Push when full cannot occur by the credit rule. The bench asserts this.
- iTopOfScreen together with a return or pop: the flush wins. The returned word is discarded, but outstanding still decrements.

## Timing
- Reset values:
  - oMemRead 0; oMemAddress FRAME_BASE.
  - oRed, oGreen, oBlue 0; oUnderflow 0; oFifoLevel 0.
  - outstanding 0; fetched 0.
- oMemRead is combinational from registered state and counters. It never depends combinationally on iMemWaitRequest.
- Push latency: a word with valid at edge N is visible on oRed/oGreen/oBlue after edge N (registered write, show-ahead read).
- Pop: the pixel shown in the cycle iPixelRequest=1 is consumed. The next pixel appears after that edge.
- Arithmetic:
  - Address is 22-bit unsigned, FRAME_BASE + fetched; no wrap within a frame.
  - fetched is 19 bits.
  - outstanding is ⌈log2(MAX_OUTSTANDING+1)⌉ bits.
- Deassertion of asynchronous reset mid-frame: the block sits in WAIT_SYNC and outputs 0 until the next iTopOfScreen. Reads in flight at reset are ignored because outstanding resets to 0. The system resets memory together with this block.

## Structure
- Shared package:
  - Pixel field positions: R_MSB=11, G_MSB=7, B_MSB=3.
  - State enum.
  - 640×480 frame constants shared with the VGA controller.
- One sub-module, pixel_fifo:
  - Synchronous, show-ahead, DEPTH×12.
  - Ports: push, pop, level, empty, full.
  - clear input with priority over push and pop.

## Test plan
- After reset, pulse iTopOfScreen with iMemWaitRequest=0 and 2-cycle read latency:
  - Addresses 0..63 issued; never more than 8 outstanding.
  - oFifoLevel saturates at 64.
  - Word 0x0ABC appears as R=A, G=B, B=C.
- Pop every cycle for 640 cycles while memory returns data: the pixel sequence matches addresses 0..639 in order, and oUnderflow stays 0.
- Hold iMemWaitRequest=1 for 5 cycles on address 17: oMemRead=1 and oMemAddress=17 are stable throughout; exactly one accept.
- Assert iTopOfScreen with 6 reads outstanding:
  - The 6 returned words are dropped.
  - FIFO level is 0.
  - The next issued address is FRAME_BASE after outstanding reaches 0.
- Pop with the FIFO empty: oUnderflow goes to 1 and stays set until the next iTopOfScreen; outputs are 0.
- Run a full frame of PIXELS=307200 words: exactly 307200 accepts, then oMemRead stays 0 until iTopOfScreen.

Source files
------------

// File: rtl/vga_pixel_fetcher_pkg.sv
// Shared definitions for the VGA pixel fetcher and its FIFO.
// Contents:
//   - pixel field positions inside a 16-bit framebuffer word
//   - 640x480 frame constants shared with the VGA controller
//   - fetcher state enum, packed RGB type and a word unpack helper
package vga_pixel_fetcher_pkg;

    localparam int R_MSB = 11;
    localparam int G_MSB = 7;
    localparam int B_MSB = 3;

    localparam int H_VISIBLE    = 640;
    localparam int V_VISIBLE    = 480;
    localparam int FRAME_PIXELS = H_VISIBLE * V_VISIBLE;

    localparam int ADDR_W  = 22;
    localparam int FETCH_W = 19;
    localparam int PIXEL_W = 12;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        FLUSH     = 2'd1,
        FETCH     = 2'd2
    } fetchState_t;

    typedef struct packed {
        logic [3:0] red;
        logic [3:0] green;
        logic [3:0] blue;
    } rgb_t;

    // Pull the three colour nibbles out of a framebuffer word; [15:12] is unused.
    function automatic rgb_t unpackPixel(input logic [15:0] word);
        rgb_t pixel;
        pixel.red   = word[R_MSB -: 4];
        pixel.green = word[G_MSB -: 4];
        pixel.blue  = word[B_MSB -: 4];
        return pixel;
    endfunction

endpackage

// File: rtl/vga_pixel_fetcher_fifo.sv
// pixel_fifo: synchronous show-ahead FIFO, DEPTH x WIDTH.
// Ports:
//   iCLK, iRST_N   clock, asynchronous active-low reset
//   iClear         empties the FIFO; wins over push and pop
//   iPush, iPushData  write one entry (ignored when full)
//   iPop           advance the head (ignored when empty)
//   oHeadData      current head entry, valid whenever oEmpty=0
//   oLevel         occupancy 0..DEPTH
//   oEmpty, oFull  status flags
module pixel_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 12
) (
    input  logic                     iCLK,
    input  logic                     iRST_N,
    input  logic                     iClear,
    input  logic                     iPush,
    input  logic [WIDTH-1:0]         iPushData,
    input  logic                     iPop,
    output logic [WIDTH-1:0]         oHeadData,
    output logic [$clog2(DEPTH):0]   oLevel,
    output logic                     oEmpty,
    output logic                     oFull
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LEVEL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doPush;
    logic             doPop;

    assign oEmpty = (oLevel == '0);
    assign oFull  = (oLevel == LEVEL_W'(DEPTH));
    assign doPush = iPush & ~oFull;
    assign doPop  = iPop & ~oEmpty;

    // Show-ahead: the head is a plain read of the slot under the read pointer.
    assign oHeadData = mem[rdPtr];

    // NOTE: the storage array has no reset; only pointers and level need a known
    // value, and leaving the array unreset lets it map onto RAM.
    always_ff @(posedge iCLK) begin
        if (doPush && !iClear) begin
            mem[wrPtr] <= iPushData;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            oLevel <= '0;
        end else if (iClear) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            oLevel <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            if (doPush && !doPop)      oLevel <= oLevel + 1'b1;
            else if (doPop && !doPush) oLevel <= oLevel - 1'b1;
        end
    end

endmodule

// File: rtl/vga_pixel_fetcher.sv
// vga_pixel_fetcher: prefetches framebuffer words over an Avalon-style
// pipelined read master and hands them to the VGA controller one pixel per
// request through a show-ahead FIFO.
// Ports:
//   iCLK, iRST_N          pixel clock, asynchronous active-low reset
//   iPixelRequest         pop one pixel (controller oRequest)
//   iTopOfScreen          restart the frame (controller oTopOfScreen)
//   oRed/oGreen/oBlue     FIFO head pixel, 0 while the FIFO is empty
//   oMemRead, oMemAddress read request and word address
//   iMemWaitRequest       slave stall; request and address hold
//   iMemReadDataValid, iMemReadData  returned word
//   oUnderflow            sticky: a pop found the FIFO empty
//   oFifoLevel            FIFO occupancy
module vga_pixel_fetcher
    import vga_pixel_fetcher_pkg::*;
#(
    parameter int unsigned FRAME_BASE      = 0,
    parameter int unsigned PIXELS          = FRAME_PIXELS,
    parameter int unsigned DEPTH           = 64,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iPixelRequest,
    input  logic        iTopOfScreen,
    output logic [3:0]  oRed,
    output logic [3:0]  oGreen,
    output logic [3:0]  oBlue,
    output logic        oMemRead,
    output logic [21:0] oMemAddress,
    input  logic        iMemWaitRequest,
    input  logic        iMemReadDataValid,
    input  logic [15:0] iMemReadData,
    output logic        oUnderflow,
    output logic [6:0]  oFifoLevel
);

    localparam int OUT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam int LEVEL_W = $clog2(DEPTH) + 1;
    localparam int SUM_W   = ((LEVEL_W > OUT_W) ? LEVEL_W : OUT_W) + 1;

    localparam logic [FETCH_W-1:0] PIXELS_LIMIT = FETCH_W'(PIXELS);
    localparam logic [OUT_W-1:0]   OUT_LIMIT    = OUT_W'(MAX_OUTSTANDING);
    localparam logic [SUM_W-1:0]   CREDIT_LIMIT = SUM_W'(DEPTH);

    fetchState_t          state;
    fetchState_t          nextState;
    logic [FETCH_W-1:0]   fetched;
    logic [OUT_W-1:0]     outstanding;
    logic                 readHold;
    logic                 accept;
    logic                 issueOk;
    logic [SUM_W-1:0]     creditUsed;

    logic                 fifoPush;
    logic                 fifoEmpty;
    logic                 fifoFull;
    logic [LEVEL_W-1:0]   fifoLevel;
    rgb_t                 pushPixel;
    rgb_t                 headPixel;
    logic                 unusedBits;

    assign accept = oMemRead & ~iMemWaitRequest;

    // Credit rule: FIFO entries plus reads in flight never exceed DEPTH, so a
    // returned word always has a free slot.
    assign creditUsed = SUM_W'(fifoLevel) + SUM_W'(outstanding);
    assign issueOk    = (fetched < PIXELS_LIMIT) &&
                        (outstanding < OUT_LIMIT) &&
                        (creditUsed < CREDIT_LIMIT);

    assign oMemAddress = ADDR_W'(FRAME_BASE) + ADDR_W'(fetched);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) state <= WAIT_SYNC;
        else         state <= nextState;
    end

    always_comb begin
        // NOTE: defaults first, so no path through this block leaves a signal
        // unassigned and infers a latch.
        nextState = state;
        oMemRead  = 1'b0;
        unique case (state)
            WAIT_SYNC: nextState = WAIT_SYNC;
            FLUSH:     if (outstanding == '0) nextState = FETCH;
            // A stalled request keeps asserting regardless of the credit
            // check; the issue condition is only looked at again after an accept.
            FETCH:     oMemRead = readHold | issueOk;
            default:   nextState = WAIT_SYNC;
        endcase
        if (iTopOfScreen) nextState = FLUSH;
    end

    // ----------------------------------------------------- counters/flags
    // NOTE: all state here is sequential, so every assignment is non-blocking;
    // blocking assignments would let later lines see this cycle's new values.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            fetched     <= '0;
            outstanding <= '0;
            readHold    <= 1'b0;
            oUnderflow  <= 1'b0;
        end else begin
            // Outstanding tracks the bus, not the frame: a read accepted or
            // returned during a flush still counts.
            if (accept && !iMemReadDataValid) begin
                outstanding <= outstanding + 1'b1;
            end else if (!accept && iMemReadDataValid && outstanding != '0) begin
                outstanding <= outstanding - 1'b1;
            end

            if (iTopOfScreen) begin
                fetched    <= '0;
                readHold   <= 1'b0;
                oUnderflow <= 1'b0;
            end else begin
                if (accept) fetched <= fetched + 1'b1;
                readHold <= oMemRead & iMemWaitRequest;
                if (iPixelRequest && fifoEmpty) oUnderflow <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- FIFO
    // Words returning outside FETCH belong to an abandoned frame.
    assign fifoPush  = iMemReadDataValid && (state == FETCH);
    assign pushPixel = unpackPixel(iMemReadData);

    pixel_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PIXEL_W)
    ) u_pixel_fifo (
        .iCLK      (iCLK),
        .iRST_N    (iRST_N),
        .iClear    (iTopOfScreen),
        .iPush     (fifoPush),
        .iPushData (pushPixel),
        .iPop      (iPixelRequest),
        .oHeadData (headPixel),
        .oLevel    (fifoLevel),
        .oEmpty    (fifoEmpty),
        .oFull     (fifoFull)
    );

    assign oRed       = fifoEmpty ? 4'h0 : headPixel.red;
    assign oGreen     = fifoEmpty ? 4'h0 : headPixel.green;
    assign oBlue      = fifoEmpty ? 4'h0 : headPixel.blue;
    assign oFifoLevel = 7'(fifoLevel);

    // Upper word nibble carries no colour; full is implied by the credit rule.
    assign unusedBits = ^{iMemReadData[15:12], fifoFull};

endmodule

// File: tb/tb_vga_pixel_fetcher.sv
module tb_vga_pixel_fetcher;
    import vga_pixel_fetcher_pkg::*;

    localparam int TB_PIXELS = 1000;

    logic        iCLK = 1'b0;
    logic        iRST_N;
    logic        iPixelRequest;
    logic        iTopOfScreen;
    logic [3:0]  oRed, oGreen, oBlue;
    logic        oMemRead;
    logic [21:0] oMemAddress;
    logic        iMemWaitRequest;
    logic        iMemReadDataValid;
    logic [15:0] iMemReadData;
    logic        oUnderflow;
    logic [6:0]  oFifoLevel;

    always #5 iCLK = ~iCLK;

    vga_pixel_fetcher #(
        .FRAME_BASE      (0),
        .PIXELS          (TB_PIXELS),
        .DEPTH           (64),
        .MAX_OUTSTANDING (8)
    ) dut (
        .iCLK              (iCLK),
        .iRST_N            (iRST_N),
        .iPixelRequest     (iPixelRequest),
        .iTopOfScreen      (iTopOfScreen),
        .oRed              (oRed),
        .oGreen            (oGreen),
        .oBlue             (oBlue),
        .oMemRead          (oMemRead),
        .oMemAddress       (oMemAddress),
        .iMemWaitRequest   (iMemWaitRequest),
        .iMemReadDataValid (iMemReadDataValid),
        .iMemReadData      (iMemReadData),
        .oUnderflow        (oUnderflow),
        .oFifoLevel        (oFifoLevel)
    );

    int checkCount = 0;
    int failCount  = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Memory contents: address 0 holds 0x0ABC, each next word adds 0x25 to the pixel.
    function automatic logic [11:0] pixelOf(input logic [21:0] addr);
        logic [11:0] step;
        step = 12'(addr[11:0] * 12'd37);
        return 12'hABC + step;
    endfunction

    function automatic logic [15:0] memWord(input logic [21:0] addr);
        return {addr[3:0], pixelOf(addr)};
    endfunction

    // ---------------- memory model + reference model state
    logic        slotV [16];
    logic [21:0] slotA [16];
    int          tickCount = 0;
    int          lat = 2;

    logic [21:0] q[$];
    fetchState_t mode = WAIT_SYNC;
    logic        ufModel = 1'b0;
    int          outModel = 0;
    int          maxOut = 0;
    int          nextAddr = 0;
    int          frameAccepts = 0;
    int          dropped = 0;
    int          popCount = 0;
    logic [21:0] lastPopAddr = '0;
    logic        lastAcc = 1'b0;
    logic [21:0] lastAccAddr = '0;
    int          accOutBefore = 0;

    int levelErr = 0, pixErr = 0, ufErr = 0, addrErr = 0, pushFullErr = 0;

    // One clock cycle: sample DUT outputs at the falling edge, compare with the
    // model, then drive this cycle's inputs and advance the model.
    task automatic tick(input logic req, input logic tos, input logic stall);
        logic        ret;
        logic [21:0] rAddr;
        int          outBefore;
        int          slot;
        @(negedge iCLK);
        if (int'(oFifoLevel) != q.size()) levelErr++;
        if (q.size() > 0) begin
            if ({oRed, oGreen, oBlue} !== pixelOf(q[0])) pixErr++;
        end else if ({oRed, oGreen, oBlue} !== 12'h000) begin
            pixErr++;
        end
        if (oUnderflow !== ufModel) ufErr++;

        slot  = tickCount % 16;
        ret   = slotV[slot];
        rAddr = slotA[slot];
        slotV[slot] = 1'b0;
        iMemReadDataValid = ret;
        iMemReadData      = ret ? memWord(rAddr) : 16'h0000;
        iPixelRequest     = req;
        iTopOfScreen      = tos;
        iMemWaitRequest   = stall;

        if (ret && !tos && mode == FETCH && oFifoLevel == 7'd64 && !req) pushFullErr++;

        lastAcc = oMemRead && !stall;
        outBefore = outModel;
        if (lastAcc) begin
            lastAccAddr  = oMemAddress;
            accOutBefore = outBefore;
            if (oMemAddress !== 22'(nextAddr)) addrErr++;
            nextAddr++;
            frameAccepts++;
            slotV[(tickCount + lat) % 16] = 1'b1;
            slotA[(tickCount + lat) % 16] = oMemAddress;
        end

        if (tos) begin
            q.delete();
            ufModel = 1'b0;
            mode = FLUSH;
            nextAddr = 0;
            frameAccepts = 0;
            if (ret) dropped++;
        end else begin
            if (req) begin
                if (q.size() > 0) begin
                    lastPopAddr = q.pop_front();
                    popCount++;
                end else begin
                    ufModel = 1'b1;
                end
            end
            if (ret) begin
                if (mode == FETCH) q.push_back(rAddr);
                else dropped++;
            end
            if (mode == FLUSH && outBefore == 0) mode = FETCH;
        end

        outModel = outModel + (lastAcc ? 1 : 0) - (ret ? 1 : 0);
        if (outModel > maxOut) maxOut = outModel;
        tickCount++;
    endtask

    // Restart the frame with the slave stalled so nothing is accepted, wait for
    // the flush to finish, then change read latency while the bus is idle.
    task automatic drainIdle(input int newLat);
        tick(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 100 && !(outModel == 0 && mode == FETCH); i++) tick(1'b0, 1'b0, 1'b1);
        check("drain_idle", 32'(outModel == 0 && mode == FETCH), 32'd1);
        lat = newLat;
    endtask

    typedef struct {
        logic       pop;
        logic [3:0] red;
        logic [3:0] green;
        logic [3:0] blue;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int levelMax;
        int holdErr;
        int accBefore;
        int extraAcc;
        int readHigh;

        vecs[0] = '{pop: 1'b1, red: 4'hA, green: 4'hB, blue: 4'hC};
        vecs[1] = '{pop: 1'b0, red: 4'hA, green: 4'hE, blue: 4'h1};
        vecs[2] = '{pop: 1'b1, red: 4'hA, green: 4'hE, blue: 4'h1};
        vecs[3] = '{pop: 1'b1, red: 4'hB, green: 4'h0, blue: 4'h6};
        vecs[4] = '{pop: 1'b1, red: 4'hB, green: 4'h2, blue: 4'hB};

        for (int i = 0; i < 16; i++) begin
            slotV[i] = 1'b0;
            slotA[i] = '0;
        end
        iRST_N = 1'b0;
        iPixelRequest = 1'b0;
        iTopOfScreen = 1'b0;
        iMemWaitRequest = 1'b0;
        iMemReadDataValid = 1'b0;
        iMemReadData = 16'h0;

        // ---- reset values
        repeat (3) @(negedge iCLK);
        iRST_N = 1'b1;
        @(negedge iCLK);
        check("rst_mem_read", 32'(oMemRead), 32'd0);
        check("rst_mem_address", 32'(oMemAddress), 32'd0);
        check("rst_rgb", 32'({oRed, oGreen, oBlue}), 32'h000);
        check("rst_underflow", 32'(oUnderflow), 32'd0);
        check("rst_level", 32'(oFifoLevel), 32'd0);
        repeat (5) tick(1'b0, 1'b0, 1'b0);
        check("wait_sync_no_read", 32'(oMemRead), 32'd0);

        // ---- fill after top of screen, long latency so outstanding saturates
        lat = 12;
        tick(1'b0, 1'b1, 1'b0);
        repeat (120) tick(1'b0, 1'b0, 1'b0);
        check("fill_level", 32'(oFifoLevel), 32'd64);
        check("fill_accepts", 32'(frameAccepts), 32'd64);
        check("fill_max_outstanding", 32'(maxOut), 32'd8);
        check("fill_read_idle", 32'(oMemRead), 32'd0);

        // ---- table-driven head pixels (0x0ABC first)
        for (int i = 0; i < 5; i++) begin
            tick(vecs[i].pop, 1'b0, 1'b0);
            check($sformatf("vec%0d_rgb", i), 32'({oRed, oGreen, oBlue}),
                  32'({vecs[i].red, vecs[i].green, vecs[i].blue}));
        end

        // ---- 640 pops in a row while memory keeps returning data
        drainIdle(2);
        repeat (100) tick(1'b0, 1'b0, 1'b0);
        popCount = 0;
        repeat (640) tick(1'b1, 1'b0, 1'b0);
        check("line_pop_count", 32'(popCount), 32'd640);
        check("line_last_addr", 32'(lastPopAddr), 32'd639);
        check("line_underflow", 32'(oUnderflow), 32'd0);

        // ---- wait state on address 17
        drainIdle(2);
        for (int i = 0; i < 100 && nextAddr != 17; i++) tick(1'b0, 1'b0, 1'b0);
        check("hold_reach_17", 32'(nextAddr), 32'd17);
        accBefore = frameAccepts;
        holdErr = 0;
        repeat (5) begin
            tick(1'b0, 1'b0, 1'b1);
            if (oMemRead !== 1'b1 || oMemAddress !== 22'd17) holdErr++;
        end
        check("hold_stable", 32'(holdErr), 32'd0);
        check("hold_no_accept", 32'(frameAccepts - accBefore), 32'd0);
        tick(1'b0, 1'b0, 1'b0);
        check("hold_accept_addr", 32'(lastAccAddr), 32'd17);
        check("hold_one_accept", 32'(frameAccepts - accBefore), 32'd1);

        // ---- top of screen with 6 reads in flight
        drainIdle(12);
        for (int i = 0; i < 20 && outModel != 6; i++) tick(1'b0, 1'b0, 1'b0);
        check("flush_six_outstanding", 32'(outModel), 32'd6);
        dropped = 0;
        tick(1'b0, 1'b1, 1'b1);
        levelMax = 0;
        lastAcc = 1'b0;
        for (int i = 0; i < 60 && !lastAcc; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            if (int'(oFifoLevel) > levelMax) levelMax = int'(oFifoLevel);
        end
        check("flush_reissue", 32'(lastAcc), 32'd1);
        check("flush_first_addr", 32'(lastAccAddr), 32'd0);
        check("flush_out_zero_first", 32'(accOutBefore), 32'd0);
        check("flush_dropped", 32'(dropped), 32'd6);
        check("flush_level_zero", 32'(levelMax), 32'd0);
        drainIdle(2);

        // ---- underflow is sticky until the next top of screen
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        check("uf_rgb_zero", 32'({oRed, oGreen, oBlue}), 32'h000);
        tick(1'b0, 1'b0, 1'b0);
        check("uf_set", 32'(oUnderflow), 32'd1);
        repeat (20) tick(1'b0, 1'b0, 1'b0);
        check("uf_sticky", 32'(oUnderflow), 32'd1);
        check("uf_refilled", 32'(oFifoLevel != 7'd0), 32'd1);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check("uf_cleared", 32'(oUnderflow), 32'd0);

        // ---- whole frame, then reads stop until top of screen
        tick(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5000 && frameAccepts < TB_PIXELS; i++) tick(1'b1, 1'b0, 1'b0);
        check("frame_accepts", 32'(frameAccepts), 32'(TB_PIXELS));
        check("frame_last_addr", 32'(lastAccAddr), 32'(TB_PIXELS - 1));
        extraAcc = 0;
        readHigh = 0;
        repeat (40) begin
            tick(1'b1, 1'b0, 1'b0);
            if (lastAcc) extraAcc++;
            if (oMemRead !== 1'b0) readHigh++;
        end
        check("frame_end_no_accept", 32'(extraAcc), 32'd0);
        check("frame_end_read_low", 32'(readHigh), 32'd0);
        tick(1'b0, 1'b1, 1'b0);
        lastAcc = 1'b0;
        for (int i = 0; i < 40 && !lastAcc; i++) tick(1'b0, 1'b0, 1'b0);
        check("new_frame_restart", 32'(lastAcc), 32'd1);
        check("new_frame_addr", 32'(lastAccAddr), 32'd0);

        // ---- cycle-by-cycle model agreement over the whole run
        check("model_level", 32'(levelErr), 32'd0);
        check("model_pixels", 32'(pixErr), 32'd0);
        check("model_underflow", 32'(ufErr), 32'd0);
        check("model_addresses", 32'(addrErr), 32'd0);
        check("no_push_when_full", 32'(pushFullErr), 32'd0);
        check("outstanding_le_8", 32'(maxOut <= 8), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
